// File: rtl/dac_adc_sweep.sv
// dac_adc_sweep: linear DAC code sweep with averaged ADC readback.
//   For each of npts points: strobe the DAC controller with the current code,
//   wait for its end flag, hold settle cycles, then average 2^NAVG_LOG2 ADC
//   conversions and offer the result on a valid/ready handshake.
// Ports:
//   clk_i, rst_i (async, active low)
//   start_i, abort_i                  : sweep control
//   code_start_i, code_step_i, npts_i,
//   settle_i                          : sweep config, latched on start
//   stdac_o, dac_code_o, eodac_i      : DAC controller interface
//   stadc_o, eoadc_i, adc_data_i      : ADC controller interface
//   avg_o, idx_o, valid_o, ready_i    : result stream
//   busy_o, done_o                    : status
// Optional: define DAC_ADC_TIMEOUT_EN to bound the DAC/ADC waits (param TMO_W,
//   output err_o pulses when a wait times out).
module dac_adc_sweep #(
  parameter int DAC_W     = 12,
  parameter int ADC_W     = 12,
  parameter int NAVG_LOG2 = 2,
  parameter int NPTS_W    = 8,
  parameter int SETTLE_W  = 8
`ifdef DAC_ADC_TIMEOUT_EN
  , parameter int TMO_W   = 16
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [DAC_W-1:0]    code_start_i,
  input  logic [DAC_W-1:0]    code_step_i,
  input  logic [NPTS_W-1:0]   npts_i,
  input  logic [SETTLE_W-1:0] settle_i,
  output logic                stdac_o,
  output logic [DAC_W-1:0]    dac_code_o,
  input  logic                eodac_i,
  output logic                stadc_o,
  input  logic                eoadc_i,
  input  logic [ADC_W-1:0]    adc_data_i,
  output logic [ADC_W-1:0]    avg_o,
  output logic [NPTS_W-1:0]   idx_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                busy_o,
  output logic                done_o
`ifdef DAC_ADC_TIMEOUT_EN
  , output logic              err_o
`endif
);

  localparam int ACC_W  = ADC_W + NAVG_LOG2;
  localparam int CNT_W  = NAVG_LOG2 + 1;
  localparam int NSMP_I = 1 << NAVG_LOG2;

  typedef enum logic [3:0] {
    S_IDLE, S_DAC_ST, S_DAC_GAP, S_DAC_WAIT, S_SETTLE,
    S_ADC_ST, S_ADC_GAP, S_ADC_WAIT, S_OUT
  } state_t;

  state_t              r_state, w_nxt;
  logic [DAC_W-1:0]    r_code, r_step;
  logic [NPTS_W-1:0]   r_npts, r_idx, r_idx_o;
  logic [SETTLE_W-1:0] r_settle, r_scnt;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADC_W-1:0]    r_avg;
  logic                r_done;

  logic [ACC_W-1:0]    w_acc_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_last_smp, w_last_pt;

  assign w_acc_nxt  = r_acc + ACC_W'(adc_data_i);
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_last_smp = (w_cnt_nxt == CNT_W'(NSMP_I));
  assign w_last_pt  = (r_idx == r_npts - NPTS_W'(1));

`ifdef DAC_ADC_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic             w_wait, w_tmo_hit, r_err;

  // counter only runs while a wait is still outstanding; any other state clears it
  assign w_wait    = ((r_state == S_DAC_WAIT) && !eodac_i) ||
                     ((r_state == S_ADC_WAIT) && !eoadc_i);
  assign w_tmo_nxt = r_tmo + TMO_W'(1);
  assign w_tmo_hit = w_wait && (w_tmo_nxt == {TMO_W{1'b1}});
  assign err_o     = r_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= w_wait ? w_tmo_nxt : '0;
      r_err <= w_tmo_hit && !abort_i;
    end
  end
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start_i && (npts_i != '0)) w_nxt = S_DAC_ST;
      S_DAC_ST:   w_nxt = S_DAC_GAP;
      S_DAC_GAP:  w_nxt = S_DAC_WAIT;  // stale eodac_i from previous transfer ignored
      S_DAC_WAIT: if (eodac_i) w_nxt = (r_settle == '0) ? S_ADC_ST : S_SETTLE;
      S_SETTLE:   if (r_scnt <= SETTLE_W'(1)) w_nxt = S_ADC_ST;
      S_ADC_ST:   w_nxt = S_ADC_GAP;
      S_ADC_GAP:  w_nxt = S_ADC_WAIT;
      S_ADC_WAIT: if (eoadc_i) w_nxt = w_last_smp ? S_OUT : S_ADC_ST;
      S_OUT:      if (ready_i) w_nxt = w_last_pt ? S_IDLE : S_DAC_ST;
      default:    w_nxt = S_IDLE;
    endcase
`ifdef DAC_ADC_TIMEOUT_EN
    if (w_tmo_hit) w_nxt = S_IDLE;
`endif
    if (abort_i) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_code   <= '0;
      r_step   <= '0;
      r_npts   <= '0;
      r_settle <= '0;
      r_scnt   <= '0;
      r_idx    <= '0;
      r_idx_o  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_avg    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i && !abort_i) begin
          r_code   <= code_start_i;
          r_step   <= code_step_i;
          r_npts   <= npts_i;
          r_settle <= settle_i;
          r_idx    <= '0;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_done   <= (npts_i == '0);  // empty sweep completes immediately
        end
        S_DAC_WAIT: if (eodac_i) r_scnt <= r_settle;
        S_SETTLE:   r_scnt <= r_scnt - SETTLE_W'(1);
        S_ADC_WAIT: if (eoadc_i && !abort_i) begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
          if (w_last_smp) begin
            r_avg   <= w_acc_nxt[ACC_W-1:NAVG_LOG2];  // truncating divide by 2^NAVG_LOG2
            r_idx_o <= r_idx;
          end
        end
        S_OUT: if (ready_i && !abort_i) begin
          if (w_last_pt) r_done <= 1'b1;
          else begin
            r_code <= r_code + r_step;
            r_idx  <= r_idx + NPTS_W'(1);
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stdac_o    = (r_state == S_DAC_ST);
  assign stadc_o    = (r_state == S_ADC_ST);
  assign valid_o    = (r_state == S_OUT);
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = r_done;
  assign dac_code_o = r_code;
  assign avg_o      = r_avg;
  assign idx_o      = r_idx_o;

endmodule

// File: tb/tb_dac_adc_sweep.sv
// Bench for dac_adc_sweep: emulates the DAC/ADC controllers with random
// latencies and data, and predicts strobe timing, codes and averages from
// the sweep rules directly.
module tb_dac_adc_sweep;
  localparam int NAVG = 2;
  localparam int NSMP = 1 << NAVG;

  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0;
  logic [11:0] code_start_i = '0, code_step_i = '0, adc_data_i = '0;
  logic [7:0]  npts_i = '0, settle_i = '0;
  logic        eodac_i = 1'b0, eoadc_i = 1'b0, ready_i = 1'b0;
  logic        stdac_o, stadc_o, valid_o, busy_o, done_o;
  logic [11:0] dac_code_o, avg_o;
  logic [7:0]  idx_o;

  int n_vec = 0, n_err = 0, cyc = 0;

  dac_adc_sweep #(.DAC_W(12), .ADC_W(12), .NAVG_LOG2(NAVG), .NPTS_W(8), .SETTLE_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .code_start_i(code_start_i), .code_step_i(code_step_i), .npts_i(npts_i),
    .settle_i(settle_i), .stdac_o(stdac_o), .dac_code_o(dac_code_o),
    .eodac_i(eodac_i), .stadc_o(stadc_o), .eoadc_i(eoadc_i),
    .adc_data_i(adc_data_i), .avg_o(avg_o), .idx_o(idx_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1; cyc++;
  endtask

  // One complete sweep. rmode: 0 random ready, 1 ready always, 2 ready held
  // low for the first 10 valid cycles. abort_pt >= 0 aborts in the ADC wait
  // of the second conversion of that point.
  task automatic sweep(input logic [11:0] cs, input logic [11:0] st, input int np,
                       input int sett, input int rmode, input bit seq,
                       input bit force_stale, input int abort_pt);
    int k = 0, smp = 0, sum = 0, lim, ocnt = 0;
    int stdac_cyc = -100, stadc_cyc = -100, dac_dly = 2, adc_dly = 2;
    int exp_stadc = -1, valid_from = -1;
    bit exp_stdac, stale = 1'b0, vexp, hs, fin = 1'b0, ab;
    logic [11:0] exp_code, exp_avg;
    code_start_i = cs; code_step_i = st; npts_i = 8'(np); settle_i = 8'(sett);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    // scramble config to show it was latched
    code_start_i = 12'($urandom); code_step_i = 12'($urandom);
    npts_i = 8'($urandom); settle_i = 8'($urandom);
    exp_code = cs; exp_stdac = 1'b1; lim = cyc + 3000;
    while (!fin && cyc < lim) begin
      vexp    = (valid_from >= 0) && (cyc >= valid_from);
      exp_avg = 12'(sum >> NAVG);
      chk("stdac", stdac_o, exp_stdac);
      chk("stadc", stadc_o, cyc == exp_stadc);
      chk("valid", valid_o, vexp);
      chk("busy", busy_o, 1);
      chk("done", done_o, 0);
      chk("code", dac_code_o, exp_code);
      if (vexp) begin
        chk("avg", avg_o, exp_avg);
        chk("idx", idx_o, k);
      end
      if (exp_stdac) begin
        stdac_cyc = cyc; dac_dly = $urandom_range(2, 5);
        stale = force_stale | 1'($urandom_range(0, 1));
        sum = 0; smp = 0;
      end
      if (cyc == exp_stadc) begin
        stadc_cyc = cyc; adc_dly = $urandom_range(2, 5); exp_stadc = -1;
      end
      exp_stdac = 1'b0;
      // DAC end flag: optionally left high from the last transfer through the gap
      if (cyc - stdac_cyc < 2) eodac_i = stale;
      else if (cyc - stdac_cyc < dac_dly) eodac_i = 1'b0;
      else begin
        if (cyc - stdac_cyc == dac_dly) exp_stadc = cyc + sett + 1;
        eodac_i = 1'b1;
      end
      ab = (k == abort_pt) && (smp == 1) && (cyc == stadc_cyc + 2);
      // ADC: possible junk pulse in the gap, then the real conversion
      eoadc_i = 1'b0; adc_data_i = 12'($urandom);
      if (cyc == stadc_cyc + 1) eoadc_i = 1'($urandom_range(0, 1));
      else if (cyc == stadc_cyc + adc_dly && !ab) begin
        eoadc_i = 1'b1;
        if (seq) adc_data_i = 12'(10 + smp);
        sum += int'(adc_data_i);
        smp++;
        if (smp < NSMP) exp_stadc = cyc + 1;
        else valid_from = cyc + 1;
      end
      if (vexp) begin
        if (rmode == 1) ready_i = 1'b1;
        else if (rmode == 2) ready_i = (ocnt >= 10);
        else ready_i = ($urandom_range(0, 2) == 0);
        ocnt++;
      end else ready_i = 1'($urandom_range(0, 1));
      start_i = 1'($urandom_range(0, 1));  // must be ignored while busy
      hs = vexp && ready_i;
      if (ab) begin
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0; start_i = 1'b0; eoadc_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
          chk("ab_busy", busy_o, 0);
          chk("ab_valid", valid_o, 0);
          chk("ab_done", done_o, 0);
          chk("ab_stdac", stdac_o, 0);
          chk("ab_stadc", stadc_o, 0);
          tick();
        end
        ready_i = 1'b0;
        return;
      end
      tick();
      if (hs) begin
        valid_from = -1;
        if (k == np - 1) fin = 1'b1;
        else begin
          k++; exp_code = exp_code + st; exp_stdac = 1'b1;
        end
      end
    end
    start_i = 1'b0; ready_i = 1'b0; eoadc_i = 1'b0;
    if (!fin) chk("sweep_timeout", 0, 1);
    else begin
      chk("fin_done", done_o, 1);
      chk("fin_busy", busy_o, 0);
      chk("fin_valid", valid_o, 0);
      chk("fin_stdac", stdac_o, 0);
      tick();
      chk("done_pulse", done_o, 0);
      chk("idle_busy", busy_o, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int np;
    repeat (3) tick();
    chk("rst_stdac", stdac_o, 0);
    chk("rst_stadc", stadc_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_code", dac_code_o, 0);
    chk("rst_avg", avg_o, 0);
    chk("rst_idx", idx_o, 0);
    rst_i = 1'b1;
    tick();

    sweep(12'h123, 12'h000, 1, 0, 1, 1'b0, 1'b0, -1);   // single point
    sweep(12'h100, 12'h010, 3, 0, 1, 1'b1, 1'b0, -1);   // 10..13 -> avg 11
    sweep(12'hFF0, 12'h020, 2, 3, 0, 1'b0, 1'b0, -1);   // code wrap
    sweep(12'h200, 12'h001, 2, 5, 1, 1'b0, 1'b1, -1);   // stale eodac + settle 5
    sweep(12'h300, 12'h100, 2, 1, 2, 1'b0, 1'b0, -1);   // ready held low
    sweep(12'h050, 12'h005, 3, 2, 0, 1'b0, 1'b0, 1);    // abort on point 1

    // empty sweep: done pulse, no strobes
    npts_i = 8'd0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("np0_done", done_o, 1);
    chk("np0_busy", busy_o, 0);
    chk("np0_stdac", stdac_o, 0);
    tick();
    chk("np0_done_pulse", done_o, 0);
    chk("np0_stdac2", stdac_o, 0);

    for (int t = 0; t < 8; t++) begin
      np = $urandom_range(1, 5);
      sweep(12'($urandom), 12'($urandom), np, $urandom_range(0, 6), 0, 1'b0, 1'b0,
            (t == 3) ? int'($urandom_range(0, np - 1)) : -1);
    end
    sweep(12'h7FF, 12'h001, 2, 0, 1, 1'b1, 1'b0, -1);   // recovery check

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
